// File: rtl/cap_xfer_seq.sv
// Capability record transfer sequencer between the MA stage and data memory.
// Expands one CLD/CST request into the fixed 10-word record access sequence.
module cap_xfer_seq #(
  parameter int WORD_W    = 24,
  parameter int ADDR_W    = 48,
  parameter int REC_WORDS = 10
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_req_valid,
  output logic              ow_req_ready,
  input  logic              iw_req_store,
  input  logic [ADDR_W-1:0] iw_req_addr,
  input  logic [1:0]        iw_req_cr_idx,
  input  logic [ADDR_W-1:0] iw_win_base,
  input  logic [ADDR_W-1:0] iw_win_len,
  input  logic [ADDR_W-1:0] iw_src_base,
  input  logic [ADDR_W-1:0] iw_src_len,
  input  logic [ADDR_W-1:0] iw_src_cur,
  input  logic [WORD_W-1:0] iw_src_perms,
  input  logic [WORD_W-1:0] iw_src_attr,
  input  logic              iw_src_tag,
  input  logic              iw_flush,
  output logic              ow_mem_en,
  output logic              ow_mem_we,
  output logic [ADDR_W-1:0] ow_mem_addr,
  output logic [WORD_W-1:0] ow_mem_wdata,
  input  logic [WORD_W-1:0] iw_mem_rdata,
  output logic              ow_done,
  output logic              ow_fault,
  output logic              ow_cr_we,
  output logic [1:0]        ow_cr_idx,
  output logic [ADDR_W-1:0] ow_cr_base,
  output logic [ADDR_W-1:0] ow_cr_len,
  output logic [ADDR_W-1:0] ow_cr_cur,
  output logic [WORD_W-1:0] ow_cr_perms,
  output logic [WORD_W-1:0] ow_cr_attr,
  output logic              ow_cr_tag
);

  localparam int IDX_W = $clog2(REC_WORDS);
  localparam int HI_W  = ADDR_W - WORD_W;

  localparam logic [IDX_W-1:0] I_BASE_LO = IDX_W'(0);
  localparam logic [IDX_W-1:0] I_BASE_HI = IDX_W'(1);
  localparam logic [IDX_W-1:0] I_LEN_LO  = IDX_W'(2);
  localparam logic [IDX_W-1:0] I_LEN_HI  = IDX_W'(3);
  localparam logic [IDX_W-1:0] I_CUR_LO  = IDX_W'(4);
  localparam logic [IDX_W-1:0] I_CUR_HI  = IDX_W'(5);
  localparam logic [IDX_W-1:0] I_PERMS   = IDX_W'(6);
  localparam logic [IDX_W-1:0] I_ATTR    = IDX_W'(7);
  localparam logic [IDX_W-1:0] I_TAG     = IDX_W'(8);
  localparam logic [IDX_W-1:0] I_LAST    = IDX_W'(REC_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_XFER,
    S_DRAIN,
    S_DONE,
    S_FAULT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;

  logic              r_store;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_req_idx;
  logic [ADDR_W-1:0] r_src_base;
  logic [ADDR_W-1:0] r_src_len;
  logic [ADDR_W-1:0] r_src_cur;
  logic [WORD_W-1:0] r_src_perms;
  logic [WORD_W-1:0] r_src_attr;
  logic              r_src_tag;

  logic [ADDR_W-1:0] r_asm_base;
  logic [ADDR_W-1:0] r_asm_len;
  logic [ADDR_W-1:0] r_asm_cur;
  logic [WORD_W-1:0] r_asm_perms;
  logic [WORD_W-1:0] r_asm_attr;
  logic              r_asm_tag;

  logic [1:0]        r_cr_idx;
  logic [ADDR_W-1:0] r_cr_base;
  logic [ADDR_W-1:0] r_cr_len;
  logic [ADDR_W-1:0] r_cr_cur;
  logic [WORD_W-1:0] r_cr_perms;
  logic [WORD_W-1:0] r_cr_attr;
  logic              r_cr_tag;

  logic              vld_p1;
  logic [IDX_W-1:0]  rd_idx_p1;

  logic              w_accept;
  logic              w_mem_en;
  logic              w_done;
  logic              w_fault;
  logic              w_cr_we;
  logic [WORD_W-1:0] w_wdata;

  // The record end is computed one bit wider so a window near the top of the
  // address space cannot wrap and pass the check.
  function automatic logic out_of_window(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] base,
                                         input logic [ADDR_W-1:0] len);
    logic [ADDR_W:0] rec_end;
    logic [ADDR_W:0] win_end;
    rec_end = {1'b0, addr} + (ADDR_W+1)'(REC_WORDS);
    win_end = {1'b0, base} + {1'b0, len};
    return (addr < base) || (rec_end > win_end);
  endfunction

  assign w_accept = iw_req_valid && (r_state == S_IDLE) && !iw_flush;

  always_comb begin
    w_state_nxt = r_state;
    w_mem_en    = 1'b0;
    w_done      = 1'b0;
    w_fault     = 1'b0;
    w_cr_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = out_of_window(iw_req_addr, iw_win_base, iw_win_len) ? S_FAULT : S_XFER;
        end
      end
      S_XFER: begin
        w_mem_en = 1'b1;
        if (r_idx == I_LAST) w_state_nxt = r_store ? S_DONE : S_DRAIN;
      end
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE: begin
        w_done      = 1'b1;
        w_cr_we     = !r_store;
        w_state_nxt = S_IDLE;
      end
      S_FAULT: begin
        w_done      = 1'b1;
        w_fault     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (iw_flush && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_mem_en    = 1'b0;
      w_done      = 1'b0;
      w_fault     = 1'b0;
      w_cr_we     = 1'b0;
    end
  end

  always_comb begin
    w_wdata = '0;
    case (r_idx)
      I_BASE_LO: w_wdata = r_src_base[WORD_W-1:0];
      I_BASE_HI: w_wdata = WORD_W'(r_src_base[ADDR_W-1:WORD_W]);
      I_LEN_LO:  w_wdata = r_src_len[WORD_W-1:0];
      I_LEN_HI:  w_wdata = WORD_W'(r_src_len[ADDR_W-1:WORD_W]);
      I_CUR_LO:  w_wdata = r_src_cur[WORD_W-1:0];
      I_CUR_HI:  w_wdata = WORD_W'(r_src_cur[ADDR_W-1:WORD_W]);
      I_PERMS:   w_wdata = r_src_perms;
      I_ATTR:    w_wdata = r_src_attr;
      I_TAG:     w_wdata = {{(WORD_W-1){1'b0}}, r_src_tag};
      default:   w_wdata = '0;
    endcase
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_idx <= '0;
      else if (w_mem_en) r_idx <= r_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge iw_clk) begin
    if (w_accept) begin
      r_store     <= iw_req_store;
      r_addr      <= iw_req_addr;
      r_req_idx   <= iw_req_cr_idx;
      r_src_base  <= iw_src_base;
      r_src_len   <= iw_src_len;
      r_src_cur   <= iw_src_cur;
      r_src_perms <= iw_src_perms;
      r_src_attr  <= iw_src_attr;
      r_src_tag   <= iw_src_tag;
    end
  end

  // Stage p0 -> p1: a read issued now returns data next cycle for this index.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) vld_p1 <= 1'b0;
    else        vld_p1 <= w_mem_en && !r_store;
    rd_idx_p1 <= r_idx;
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      r_asm_base  <= '0;
      r_asm_len   <= '0;
      r_asm_cur   <= '0;
      r_asm_perms <= '0;
      r_asm_attr  <= '0;
      r_asm_tag   <= 1'b0;
    end else if (vld_p1) begin
      case (rd_idx_p1)
        I_BASE_LO: r_asm_base[WORD_W-1:0]      <= iw_mem_rdata;
        I_BASE_HI: r_asm_base[ADDR_W-1:WORD_W] <= iw_mem_rdata[HI_W-1:0];
        I_LEN_LO:  r_asm_len[WORD_W-1:0]       <= iw_mem_rdata;
        I_LEN_HI:  r_asm_len[ADDR_W-1:WORD_W]  <= iw_mem_rdata[HI_W-1:0];
        I_CUR_LO:  r_asm_cur[WORD_W-1:0]       <= iw_mem_rdata;
        I_CUR_HI:  r_asm_cur[ADDR_W-1:WORD_W]  <= iw_mem_rdata[HI_W-1:0];
        I_PERMS:   r_asm_perms                 <= iw_mem_rdata;
        I_ATTR:    r_asm_attr                  <= iw_mem_rdata;
        I_TAG:     r_asm_tag                   <= iw_mem_rdata[0];
        default:   ;
      endcase
    end
  end

  // Stage p1 -> p2: published CR fields only change when a load completes.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      r_cr_idx   <= '0;
      r_cr_base  <= '0;
      r_cr_len   <= '0;
      r_cr_cur   <= '0;
      r_cr_perms <= '0;
      r_cr_attr  <= '0;
      r_cr_tag   <= 1'b0;
    end else if (w_cr_we) begin
      r_cr_idx   <= r_req_idx;
      r_cr_base  <= r_asm_base;
      r_cr_len   <= r_asm_len;
      r_cr_cur   <= r_asm_cur;
      r_cr_perms <= r_asm_perms;
      r_cr_attr  <= r_asm_attr;
      r_cr_tag   <= r_asm_tag;
    end
  end

  assign ow_req_ready = (r_state == S_IDLE);
  assign ow_mem_en    = w_mem_en;
  assign ow_mem_we    = w_mem_en && r_store;
  assign ow_mem_addr  = w_mem_en ? (r_addr + ADDR_W'(r_idx)) : '0;
  assign ow_mem_wdata = (w_mem_en && r_store) ? w_wdata : '0;
  assign ow_done      = w_done;
  assign ow_fault     = w_fault;
  assign ow_cr_we     = w_cr_we;
  assign ow_cr_idx    = w_cr_we ? r_req_idx   : r_cr_idx;
  assign ow_cr_base   = w_cr_we ? r_asm_base  : r_cr_base;
  assign ow_cr_len    = w_cr_we ? r_asm_len   : r_cr_len;
  assign ow_cr_cur    = w_cr_we ? r_asm_cur   : r_cr_cur;
  assign ow_cr_perms  = w_cr_we ? r_asm_perms : r_cr_perms;
  assign ow_cr_attr   = w_cr_we ? r_asm_attr  : r_cr_attr;
  assign ow_cr_tag    = w_cr_we ? r_asm_tag   : r_cr_tag;

endmodule

// File: tb/tb_cap_xfer_seq.sv
// Bench for cap_xfer_seq: directed record transfers, bounds, flush, reset and
// randomized loads/stores against a record-level reference model.
module tb_cap_xfer_seq;

  logic        iw_clk = 1'b0;
  logic        iw_rst = 1'b1;
  logic        iw_req_valid = 1'b0;
  logic        ow_req_ready;
  logic        iw_req_store = 1'b0;
  logic [47:0] iw_req_addr = '0;
  logic [1:0]  iw_req_cr_idx = '0;
  logic [47:0] iw_win_base = '0;
  logic [47:0] iw_win_len = '0;
  logic [47:0] iw_src_base = '0;
  logic [47:0] iw_src_len = '0;
  logic [47:0] iw_src_cur = '0;
  logic [23:0] iw_src_perms = '0;
  logic [23:0] iw_src_attr = '0;
  logic        iw_src_tag = 1'b0;
  logic        iw_flush = 1'b0;
  logic        ow_mem_en;
  logic        ow_mem_we;
  logic [47:0] ow_mem_addr;
  logic [23:0] ow_mem_wdata;
  logic [23:0] iw_mem_rdata = '0;
  logic        ow_done;
  logic        ow_fault;
  logic        ow_cr_we;
  logic [1:0]  ow_cr_idx;
  logic [47:0] ow_cr_base;
  logic [47:0] ow_cr_len;
  logic [47:0] ow_cr_cur;
  logic [23:0] ow_cr_perms;
  logic [23:0] ow_cr_attr;
  logic        ow_cr_tag;

  cap_xfer_seq dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst),
    .iw_req_valid(iw_req_valid), .ow_req_ready(ow_req_ready),
    .iw_req_store(iw_req_store), .iw_req_addr(iw_req_addr),
    .iw_req_cr_idx(iw_req_cr_idx), .iw_win_base(iw_win_base),
    .iw_win_len(iw_win_len), .iw_src_base(iw_src_base),
    .iw_src_len(iw_src_len), .iw_src_cur(iw_src_cur),
    .iw_src_perms(iw_src_perms), .iw_src_attr(iw_src_attr),
    .iw_src_tag(iw_src_tag), .iw_flush(iw_flush),
    .ow_mem_en(ow_mem_en), .ow_mem_we(ow_mem_we),
    .ow_mem_addr(ow_mem_addr), .ow_mem_wdata(ow_mem_wdata),
    .iw_mem_rdata(iw_mem_rdata), .ow_done(ow_done), .ow_fault(ow_fault),
    .ow_cr_we(ow_cr_we), .ow_cr_idx(ow_cr_idx), .ow_cr_base(ow_cr_base),
    .ow_cr_len(ow_cr_len), .ow_cr_cur(ow_cr_cur), .ow_cr_perms(ow_cr_perms),
    .ow_cr_attr(ow_cr_attr), .ow_cr_tag(ow_cr_tag)
  );

  always #5 iw_clk = ~iw_clk;

  // Data memory: pre holds bench-loaded contents, wr/wr_v record DUT stores.
  logic [23:0] pre  [0:1023];
  logic [23:0] wr   [0:1023];
  logic        wr_v [0:1023];

  function automatic logic [23:0] mrd(input int a);
    return wr_v[a] ? wr[a] : pre[a];
  endfunction

  always @(posedge iw_clk) begin
    if (iw_rst) begin
      for (int i = 0; i < 1024; i++) wr_v[i] <= 1'b0;
    end else if (ow_mem_en && ow_mem_we) begin
      wr[int'(ow_mem_addr[9:0])]   <= ow_mem_wdata;
      wr_v[int'(ow_mem_addr[9:0])] <= 1'b1;
    end
    if (ow_mem_en && !ow_mem_we) iw_mem_rdata <= mrd(int'(ow_mem_addr[9:0]));
    else                         iw_mem_rdata <= 24'($urandom);
  end

  int n_vec = 0;
  int n_err = 0;

  // Current request (bench side)
  logic        q_st;
  logic [47:0] q_addr, q_wb, q_wl, s_base, s_len, s_cur;
  logic [1:0]  q_idx;
  logic [23:0] s_perms, s_attr;
  logic        s_tag;
  logic [47:0] last_base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_sw(input int i);
    logic [23:0] w;
    case (i)
      0: w = s_base[23:0];  1: w = s_base[47:24];
      2: w = s_len[23:0];   3: w = s_len[47:24];
      4: w = s_cur[23:0];   5: w = s_cur[47:24];
      6: w = s_perms;       7: w = s_attr;
      8: w = {23'b0, s_tag};
      default: w = 24'h0;
    endcase
    return w;
  endfunction

  task automatic preload(input int a, input logic [23:0] w0, w1, w2, w3, w4,
                         w5, w6, w7, w8, w9);
    pre[a] = w0; pre[a+1] = w1; pre[a+2] = w2; pre[a+3] = w3; pre[a+4] = w4;
    pre[a+5] = w5; pre[a+6] = w6; pre[a+7] = w7; pre[a+8] = w8; pre[a+9] = w9;
  endtask

  // One request; flush_at / rst_at pick the cycle after acceptance (0 = none).
  task automatic xfer(input int flush_at, input int rst_at);
    bit          fault, seen, stopped, we_seen;
    int          exp_done, a;
    logic [63:0] rec_end, win_end;
    rec_end  = 64'(q_addr) + 64'd10;
    win_end  = 64'(q_wb) + 64'(q_wl);
    fault    = (q_addr < q_wb) || (rec_end > win_end);
    exp_done = fault ? 1 : (q_st ? 11 : 12);
    a        = int'(q_addr);
    seen     = 0;
    stopped  = 0;
    @(negedge iw_clk);
    chk("ready_idle", ow_req_ready, 1);
    iw_req_valid = 1; iw_req_store = q_st; iw_req_addr = q_addr;
    iw_req_cr_idx = q_idx; iw_win_base = q_wb; iw_win_len = q_wl;
    iw_src_base = s_base; iw_src_len = s_len; iw_src_cur = s_cur;
    iw_src_perms = s_perms; iw_src_attr = s_attr; iw_src_tag = s_tag;
    @(posedge iw_clk); #1;
    iw_req_valid = $urandom_range(0, 1); iw_req_store = ~q_st;
    iw_req_addr = 48'($urandom); iw_req_cr_idx = 2'($urandom);
    iw_src_base = 48'($urandom); iw_src_perms = 24'($urandom);
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) begin @(posedge iw_clk); #1; end
      iw_flush = (c == flush_at);
      iw_rst   = (c == rst_at);
      @(negedge iw_clk);
      if (c == flush_at) begin
        chk("flush_mem_en", ow_mem_en, 0);
        chk("flush_done", ow_done, 0);
        stopped = 1;
        break;
      end
      if (c == rst_at) begin stopped = 1; break; end
      if (!fault && c <= 10) begin
        chk("mem_en", ow_mem_en, 1);
        chk("mem_addr", ow_mem_addr, q_addr + 48'(c - 1));
        chk("mem_we", ow_mem_we, q_st);
        if (q_st) chk("mem_wdata", ow_mem_wdata, exp_sw(c - 1));
      end else begin
        chk("mem_idle", ow_mem_en, 0);
      end
      if (ow_done) begin
        seen = 1;
        chk("done_cycle", c, exp_done);
        chk("fault", ow_fault, fault);
        chk("cr_we", ow_cr_we, !q_st && !fault);
        if (!q_st && !fault) begin
          chk("cr_idx", ow_cr_idx, q_idx);
          chk("cr_base", ow_cr_base, {mrd(a+1), mrd(a)});
          chk("cr_len", ow_cr_len, {mrd(a+3), mrd(a+2)});
          chk("cr_cur", ow_cr_cur, {mrd(a+5), mrd(a+4)});
          chk("cr_perms", ow_cr_perms, mrd(a+6));
          chk("cr_attr", ow_cr_attr, mrd(a+7));
          chk("cr_tag", ow_cr_tag, mrd(a+8) & 24'h1);
          last_base = {mrd(a+1), mrd(a)};
        end else begin
          chk("cr_hold", ow_cr_base, last_base);
        end
        break;
      end
      chk("busy_ready", ow_req_ready, 0);
    end
    iw_req_valid = 0;
    if (stopped) begin
      @(posedge iw_clk); #1;
      iw_flush = 0; iw_rst = 0;
      @(negedge iw_clk);
      chk("abort_ready", ow_req_ready, 1);
      chk("abort_done", ow_done, 0);
      chk("abort_mem_en", ow_mem_en, 0);
      if (rst_at > 0) begin
        chk("rst_fault", ow_fault, 0);
        chk("rst_addr", ow_mem_addr, 0);
        chk("rst_cr_base", ow_cr_base, 0);
        chk("rst_cr_idx", ow_cr_idx, 0);
        last_base = '0;
        we_seen = 0;
        for (int k = 0; k < 12; k++) begin
          @(negedge iw_clk);
          we_seen = we_seen | ow_cr_we;
        end
        chk("rst_no_cr_we", we_seen, 0);
      end
    end else begin
      chk("done_seen", seen, 1);
      if (seen && q_st && !fault) begin
        for (int i = 0; i < 10; i++) chk("store_word", wr[a+i], exp_sw(i));
      end
    end
  endtask

  initial begin
    logic [23:0] old_w [0:9];
    for (int i = 0; i < 1024; i++) pre[i] = 24'($urandom);
    last_base = '0;
    iw_rst = 1;
    @(posedge iw_clk);
    @(negedge iw_clk);
    chk("rst_ready", ow_req_ready, 1);
    chk("rst_done", ow_done, 0);
    chk("rst_mem_en", ow_mem_en, 0);
    chk("rst_cr_we", ow_cr_we, 0);
    chk("rst_cr_base0", ow_cr_base, 0);
    chk("rst_cr_tag0", ow_cr_tag, 0);
    @(posedge iw_clk); #1;
    iw_rst = 0;

    // Directed CLD
    preload(300, 24'h1234, 24'h5678, 24'h50, 24'h0, 24'h1240, 24'h5678,
            24'hF0, 24'h0F, 24'h1, 24'h0);
    q_st = 0; q_addr = 300; q_idx = 1; q_wb = 300; q_wl = 64;
    s_base = 0; s_len = 0; s_cur = 0; s_perms = 0; s_attr = 0; s_tag = 0;
    xfer(0, 0);
    chk("cld_base_const", last_base, 48'h005678_001234);

    // Directed CST
    q_st = 1; q_addr = 107; q_idx = 2; q_wb = 100; q_wl = 32;
    s_base = 48'h4000; s_len = 48'h123; s_cur = 48'h4010;
    s_perms = 24'hA5A5; s_attr = 24'h55AA; s_tag = 1;
    xfer(0, 0);
    chk("cst_w6_const", wr[113], 24'h00A5A5);
    chk("cst_w8_const", wr[115], 24'h000001);

    // Bounds
    q_st = 0; q_addr = 123; q_idx = 3; xfer(0, 0);
    preload(122, 24'h11, 24'h22, 24'h33, 24'h44, 24'h55, 24'h66, 24'h77,
            24'h88, 24'hFFFFFE, 24'h99);
    q_addr = 122; xfer(0, 0);
    q_addr = 99; xfer(0, 0);

    // Flush a CST at r_idx=4
    for (int i = 0; i < 10; i++) old_w[i] = exp_sw(i);
    q_st = 1; q_addr = 107; q_wb = 100; q_wl = 32;
    s_base = 48'h0ABCDE_987654; s_len = 48'h111111_222222;
    s_cur = 48'h333333_444444; s_perms = 24'h5; s_attr = 24'h6; s_tag = 0;
    xfer(5, 0);
    for (int i = 0; i < 10; i++)
      chk("flush_mem", wr[107+i], (i < 4) ? exp_sw(i) : old_w[i]);

    // Back-to-back CLD then CST
    preload(500, 24'hABCDEF, 24'h000123, 24'h000040, 24'h0, 24'hABCE00,
            24'h000123, 24'h3, 24'h7, 24'h0, 24'hFFFFFF);
    q_st = 0; q_addr = 500; q_idx = 0; q_wb = 490; q_wl = 40;
    xfer(0, 0);
    q_st = 1; q_addr = 600; q_wb = 600; q_wl = 10;
    s_base = 48'h1; s_len = 48'hFFFFFF_FFFFFF; s_cur = 48'h800000_000001;
    s_perms = 24'h123456; s_attr = 24'h654321; s_tag = 1;
    xfer(0, 0);

    // Reset during a CLD
    q_st = 0; q_addr = 300; q_idx = 2; q_wb = 300; q_wl = 64;
    xfer(0, 5);

    // Randomized transfers
    for (int n = 0; n < 40; n++) begin
      q_st   = $urandom_range(0, 1);
      q_wb   = 48'(200 + $urandom_range(0, 400));
      q_wl   = 48'($urandom_range(0, 48));
      q_addr = q_wb - 48'd3 + 48'($urandom_range(0, int'(q_wl) + 3));
      q_idx  = 2'($urandom);
      s_base = {24'($urandom), 24'($urandom)};
      s_len  = {24'($urandom), 24'($urandom)};
      s_cur  = {24'($urandom), 24'($urandom)};
      s_perms = 24'($urandom); s_attr = 24'($urandom); s_tag = 1'($urandom);
      if (!q_st) begin
        for (int i = 0; i < 10; i++) pre[int'(q_addr) + i] = 24'($urandom);
      end
      xfer(0, 0);
    end

    repeat (2) @(negedge iw_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cap_xfer_seq.md
Name: cap_xfer_seq

Overview:
- Multi-word capability transfer sequencer in amber's memory-access path.
- Sits between the MA stage and u_dmem. Expands a single CLDcso/CSTcso request into the 10-word capability record transfer.
- Loads: assembles the record and produces a CR writeback for u_regcr.
- Stores: serialises the source CR fields into data memory.

Parameters:
- WORD_W, 24, data memory word width.
- ADDR_W, 48, address and capability base/len/cur width.
- REC_WORDS, 10, words per capability record; fixed layout below.

Ports:
- iw_clk  in  1  clock
- iw_rst  in  1  synchronous reset, active-high
- iw_req_valid  in  1  transfer request
- ow_req_ready  out  1  high only in IDLE
- iw_req_store  in  1  1=CST, 0=CLD
- iw_req_addr  in  48  record start address (cur+imm, already computed by MA)
- iw_req_cr_idx  in  2  destination CR index (CLD); echoed on writeback
- iw_win_base  in  48  authorising window base
- iw_win_len  in  48  authorising window length
- iw_src_base / iw_src_len / iw_src_cur  in  48 each  CST source fields
- iw_src_perms / iw_src_attr  in  24 each  CST source fields
- iw_src_tag  in  1  CST source tag
- iw_flush  in  1  abort current transfer
- ow_mem_en  out  1  memory access strobe
- ow_mem_we  out  1  write enable
- ow_mem_addr  out  48  word address
- ow_mem_wdata  out  24  write data
- iw_mem_rdata  in  24  read data, valid one cycle after the ow_mem_en read cycle
- ow_done  out  1  one-cycle completion pulse
- ow_fault  out  1  valid with ow_done; bounds violation
- ow_cr_we  out  1  CR writeback strobe; CLD success only
- ow_cr_idx  out  2  CR writeback index
- ow_cr_base / ow_cr_len / ow_cr_cur  out  48 each  CR writeback fields
- ow_cr_perms / ow_cr_attr  out  24 each  CR writeback fields
- ow_cr_tag  out  1  CR writeback tag

Behaviour:
- Record layout, word i at addr+i:
  - 0 BASE_LO, 1 BASE_HI
  - 2 LEN_LO, 3 LEN_HI
  - 4 CUR_LO, 5 CUR_HI
  - 6 PERMS, 7 ATTR
  - 8 TAG (bit0), 9 RESERVED
- States: IDLE, XFER, DRAIN, DONE, FAULT. Counter r_idx 0..9.
- Reset state:
  - State IDLE.
  - All outputs 0, except ow_req_ready=1.
  - Assembly registers cleared.
- IDLE:
  - Accept on iw_req_valid && ow_req_ready at edge T; latch all request inputs.
  - Bounds check uses 49-bit arithmetic with no wrap.
  - Fault if addr < win_base or addr+10 > win_base+win_len; next state FAULT, otherwise XFER with r_idx=0.
- FAULT (cycle T+1):
  - ow_done=1, ow_fault=1, ow_cr_we=0.
  - No memory access is issued.
  - Next state IDLE.
- XFER (cycles T+1..T+10):
  - ow_mem_en=1; ow_mem_addr = addr+r_idx (mod 2^48); ow_mem_we = store.
  - Store word i: low/high 24 bits of base/len/cur, perms, attr, {23'b0,tag}, 0.
  - At r_idx=9: store goes to DONE; load goes to DRAIN.
- Load capture: iw_mem_rdata captured one cycle after each read into the slot of the word index issued in the previous cycle.
  - Word 8: only bit0 is kept, as tag.
  - Word 9: read but discarded.
- DRAIN (T+11, load only): capture word 9, then go to DONE.
- DONE:
  - ow_done=1 for one cycle: store at T+11, load at T+12.
  - Load: ow_cr_we=1 and ow_cr_idx = latched index; ow_cr_* hold assembled values.
  - Store: ow_cr_we=0.
  - Next state IDLE; a new request can be accepted on the following edge.
- ow_cr_* fields:
  - Hold their last value until the next load completes.
  - Only ow_cr_we qualifies them.
- iw_flush:
  - Gates ow_mem_en combinationally in the same cycle.
  - Any non-IDLE state returns to IDLE on the next edge with no done, no fault and no cr_we.
  - Store words already written remain in memory.
  - Flush in IDLE is ignored, and a request arriving with flush is not accepted.
- iw_rst:
  - Mid-operation reset behaves like flush.
  - All outputs return to reset values.
- Request inputs are ignored outside IDLE.

Test Plan:
- CLD, window 300/64, addr 300, mem[300..309] = 1234, 5678, 50, 0, 1240, 5678, F0, 0F, 1, 0, idx 1:
  - done at T+12, cr_we=1, idx=1.
  - base = {5678,1234}, len=50, cur = {5678,1240}, perms=F0, attr=0F, tag=1.
- CST, window 100/32, addr 107, src base=4000, len=123, cur=4010, perms=A5A5, attr=55AA, tag=1:
  - mem[107..116] = 4000, 0, 123, 0, 4010, 0, 00A5A5, 0055AA, 000001, 0.
  - done at T+11, cr_we=0.
- Bounds:
  - addr 123, window 100/32 (end 133==132+1) → fault at T+1, no mem_en.
  - addr 122 → accepted.
  - addr 99 → fault.
- Flush during XFER at r_idx=4 of a CST:
  - Only mem[107..110] written; no done.
  - Back in IDLE with ready=1 next cycle.
- Back-to-back CLD then CST:
  - Second request accepted the cycle after the first done.
  - Ready low throughout XFER/DRAIN/DONE; both records correct.
- Reset asserted at T+5 of a CLD:
  - Next cycle all outputs 0, ready=1.
  - No cr_we ever pulses.
